mul_div_controller: RTL and testbench
=====================================

Name: mul_div_controller

Overview:
- Sequences the shared multiplier and iterative divider for the EX stage and owns the architectural HI/LO registers.
- Accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO request at a time from EX and holds off EX via `req_ready` until that operation has committed.
- Drives the multiplier's start pulse and the divider's level request, samples their results, and commits them to HI/LO.
- On flush, cancels any in-flight operation without touching HI/LO.

Parameters:
- MUL_LATENCY, 2: cycles from the `mul_start` cycle to the cycle in which `mul_result` is valid; legal range 1..7.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  EX presents an operation.
- req_op  in  3  operation code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are illegal.
- req_src1  in  32  rs value.
- req_src2  in  32  rt value.
- req_ready  out  1  controller can accept a request this cycle.
- flush  in  1  exception/ERET flush.
- unit_input1  out  32  latched operand 1 to multiplier and divider.
- unit_input2  out  32  latched operand 2 to multiplier and divider.
- unit_signed  out  1  signed operation (MULT/DIV).
- mul_start  out  1  one-cycle multiplier start pulse.
- mul_result  in  64  multiplier product; {hi, lo}.
- div_request_valid  out  1  level request to the divider.
- div_result_valid  in  1  divider done, one-cycle pulse.
- div_quotient  in  32  divider quotient.
- div_remainder  in  32  divider remainder.
- busy  out  1  an operation is in flight.
- done_valid  out  1  one-cycle pulse in the first cycle new HI/LO is visible.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (`reset`=0, asynchronous):
  - state=IDLE.
  - hi, lo, the operand latches, unit_signed, mul_start, div_request_valid, done_valid and the counter all 0.
  - `req_ready`=1, since it is combinational from IDLE.
  - Reset mid-operation abandons the operation; HI/LO read 0.
- FSM states: IDLE, MUL_WAIT, DIV_WAIT.
  - `req_ready` = (state==IDLE).
  - `busy` = (state!=IDLE).
- Acceptance:
  - Occurs in cycle 0 when req_valid && req_ready && !flush.
  - On accept, the operands and `unit_signed` are latched = (op==0 || op==2).
  - Operand latches hold until the next accept.
- MTHI/MTLO:
  - At the accept edge, hi<=req_src1 (MTHI) or lo<=req_src1 (MTLO).
  - State stays IDLE; `done_valid`=1 in cycle 1.
  - Back-to-back MT* requests are accepted every cycle.
- Illegal op (6, 7): accepted, no state or HI/LO change, no `done_valid`.
- MULT/MULTU:
  - Accept → MUL_WAIT; `mul_start`=1 in cycle 1 only; counter loaded with MUL_LATENCY.
  - Counter decrements each MUL_WAIT cycle after cycle 1.
  - In cycle 1+MUL_LATENCY (counter==0), `mul_result` is sampled: hi<=mul_result[63:32], lo<=mul_result[31:0].
  - State → IDLE. In cycle 2+MUL_LATENCY, `done_valid`=1 and `req_ready`=1.
- DIV/DIVU:
  - Accept → DIV_WAIT; `div_request_valid`=1 from cycle 1 for every DIV_WAIT cycle.
  - On a cycle with `div_result_valid`=1 in DIV_WAIT: lo<=div_quotient, hi<=div_remainder, state → IDLE.
  - `div_request_valid` is 0 and `done_valid`=1 in the following cycle.
  - `div_result_valid` outside DIV_WAIT is ignored.
  - Divide-by-zero: the divider's outputs are committed unchanged; there is no latency limit.
- Flush:
  - In MUL_WAIT/DIV_WAIT: state → IDLE at that edge; HI/LO unchanged; no `done_valid`; `div_request_valid` low next cycle.
  - Flush in the same cycle as the commit condition (counter==0 or `div_result_valid`): flush wins and there is no commit.
  - Flush with req_valid in IDLE: no accept, and MT* does not write.
  - Flush in IDLE with no request: no effect.
- Simultaneous events: `done_valid` from the previous commit may coincide with a new accept; both are honoured.
- Widths: all HI/LO data is 32 bits, with no extension or truncation beyond the field splits above.

Optional Feature:
- MUL_DIV_HILO_BYPASS_EN defined:
  - `hi`/`lo` outputs are combinational: they show the value being committed in the commit cycle (mul_result split, div_remainder/div_quotient, or req_src1 for MT*), otherwise the register.
  - A following MFHI/MFLO sees the result one cycle earlier.
  - The commit is suppressed under flush, so the bypass is also suppressed.
- Not defined: `hi`/`lo` are purely registered outputs.

Test Plan:
- Reset then release → hi=lo=0, req_ready=1, busy=0, all strobes 0; assert reset mid-DIV_WAIT → same values asynchronously.
- MULT src1=0xFFFFFFFE (-2), src2=3, mul_result=0xFFFFFFFF_FFFFFFFA at cycle 3 (MUL_LATENCY=2) → mul_start only in cycle 1; hi=0xFFFFFFFF, lo=0xFFFFFFFA and done_valid in cycle 4; req_ready=0 in cycles 1-3.
- DIVU 100/7 with div_result_valid after 33 cycles, quotient=14, remainder=2 → div_request_valid high throughout DIV_WAIT; lo=14, hi=2, done_valid the next cycle.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles → both accepted, hi/lo updated after each edge, done_valid in two consecutive cycles, busy stays 0.
- DIV accepted, flush in cycle 10 → IDLE next cycle, div_request_valid drops, HI/LO unchanged, no done_valid; a later div_result_valid pulse is ignored.
- Flush coincident with counter==0 in MULT, and separately with req_valid=MTLO in IDLE → no HI/LO write in either case; with the bypass macro, hi/lo show the committed value in the commit cycle of a non-flushed MULT.

Source files
------------

// File: rtl/mul_div_controller.sv
// Sequences the shared multiplier/divider for EX and owns the HI/LO registers.
// Define MUL_DIV_HILO_BYPASS_EN to make hi_o/lo_o show the value being committed in the commit cycle.
module mul_div_controller #(
  parameter int unsigned MUL_LATENCY = 2
) (
  input  logic        clock_i,
  input  logic        reset_ni,
  input  logic        req_valid_i,
  input  logic [2:0]  req_op_i,
  input  logic [31:0] req_src1_i,
  input  logic [31:0] req_src2_i,
  output logic        req_ready_o,
  input  logic        flush_i,
  output logic [31:0] unit_input1_o,
  output logic [31:0] unit_input2_o,
  output logic        unit_signed_o,
  output logic        mul_start_o,
  input  logic [63:0] mul_result_i,
  output logic        div_request_valid_o,
  input  logic        div_result_valid_i,
  input  logic [31:0] div_quotient_i,
  input  logic [31:0] div_remainder_i,
  output logic        busy_o,
  output logic        done_valid_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  // state    | meaning
  // IDLE     | ready for a request; MT*/illegal ops complete here
  // MUL_WAIT | multiplier running, counter counts down to the result cycle
  // DIV_WAIT | divider requested, waiting for its done pulse
  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT} state_e;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] LAT      = 3'(MUL_LATENCY);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] in1_q, in1_d, in2_q, in2_d;
  logic        sgn_q, sgn_d;
  logic        mul_start_q, mul_start_d;
  logic        done_q, done_d;
  logic        accept;

  assign accept = req_valid_i && (state_q == IDLE) && !flush_i;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    in1_d       = in1_q;
    in2_d       = in2_q;
    sgn_d       = sgn_q;
    mul_start_d = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          in1_d = req_src1_i;
          in2_d = req_src2_i;
          sgn_d = (req_op_i == OP_MULT) || (req_op_i == OP_DIV);
          case (req_op_i)
            OP_MULT, OP_MULTU: begin
              state_d     = MUL_WAIT;
              mul_start_d = 1'b1;
              cnt_d       = LAT;
            end
            OP_DIV, OP_DIVU: state_d = DIV_WAIT;
            OP_MTHI: begin
              hi_d   = req_src1_i;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = req_src1_i;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      // flush always beats a same-cycle commit
      MUL_WAIT: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (cnt_q == 3'd0) begin
          hi_d    = mul_result_i[63:32];
          lo_d    = mul_result_i[31:0];
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      DIV_WAIT: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (div_result_valid_i) begin
          hi_d    = div_remainder_i;
          lo_d    = div_quotient_i;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      in1_q       <= '0;
      in2_q       <= '0;
      sgn_q       <= 1'b0;
      mul_start_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
      sgn_q       <= sgn_d;
      mul_start_q <= mul_start_d;
      done_q      <= done_d;
    end
  end

  assign req_ready_o         = (state_q == IDLE);
  assign busy_o              = (state_q != IDLE);
  assign div_request_valid_o = (state_q == DIV_WAIT);
  assign mul_start_o         = mul_start_q;
  assign done_valid_o        = done_q;
  assign unit_input1_o       = in1_q;
  assign unit_input2_o       = in2_q;
  assign unit_signed_o       = sgn_q;

`ifdef MUL_DIV_HILO_BYPASS_EN
  // hi_d/lo_d equal the registers except in an unflushed commit cycle
  assign hi_o = hi_d;
  assign lo_o = lo_d;
`else
  assign hi_o = hi_q;
  assign lo_o = lo_q;
`endif

endmodule

// File: tb/tb_mul_div_controller.sv
// Randomized self-checking bench for mul_div_controller against a transaction-level HI/LO model.
module tb_mul_div_controller;
  localparam int L = 2;
`ifdef MUL_DIV_HILO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk, rst_n, req_valid, flush, div_result_valid;
  logic [2:0]  req_op;
  logic [31:0] req_src1, req_src2, div_quotient, div_remainder;
  logic [63:0] mul_result;
  logic        req_ready, unit_signed, mul_start, div_request_valid, busy, done_valid;
  logic [31:0] unit_input1, unit_input2, hi, lo;

  mul_div_controller #(.MUL_LATENCY(L)) dut (
    .clock_i(clk), .reset_ni(rst_n), .req_valid_i(req_valid), .req_op_i(req_op),
    .req_src1_i(req_src1), .req_src2_i(req_src2), .req_ready_o(req_ready), .flush_i(flush),
    .unit_input1_o(unit_input1), .unit_input2_o(unit_input2), .unit_signed_o(unit_signed),
    .mul_start_o(mul_start), .mul_result_i(mul_result), .div_request_valid_o(div_request_valid),
    .div_result_valid_i(div_result_valid), .div_quotient_i(div_quotient),
    .div_remainder_i(div_remainder), .busy_o(busy), .done_valid_o(done_valid),
    .hi_o(hi), .lo_o(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  logic [31:0] m_hi, m_lo, m_in1, m_in2;
  logic        m_sgn;
  bit          pend_done;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_cycle(input bit rdy, input bit bsy, input bit ms, input bit drv,
                             input bit dn, input logic [31:0] ehi, input logic [31:0] elo);
    check_val("req_ready", 64'(req_ready), 64'(rdy));
    check_val("busy", 64'(busy), 64'(bsy));
    check_val("mul_start", 64'(mul_start), 64'(ms));
    check_val("div_request_valid", 64'(div_request_valid), 64'(drv));
    check_val("done_valid", 64'(done_valid), 64'(dn));
    check_val("hi", 64'(hi), 64'(ehi));
    check_val("lo", 64'(lo), 64'(elo));
    check_val("unit_input1", 64'(unit_input1), 64'(m_in1));
    check_val("unit_input2", 64'(unit_input2), 64'(m_in2));
    check_val("unit_signed", 64'(unit_signed), 64'(m_sgn));
  endtask

  task automatic idle_inputs();
    req_valid        = 1'b0;
    flush            = 1'b0;
    div_result_valid = 1'b0;
    req_op           = 3'($urandom_range(0, 7));
    req_src1         = $urandom;
    req_src2         = $urandom;
    mul_result       = {$urandom, $urandom};
    div_quotient     = $urandom;
    div_remainder    = $urandom;
  endtask

  task automatic end_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_hi = '0; m_lo = '0; m_in1 = '0; m_in2 = '0; m_sgn = 1'b0; pend_done = 1'b0;
  endtask

  // one IDLE cycle with no accept: either no request, or a request blocked by flush
  task automatic do_idle(input bit fl, input bit rv, input bit [2:0] op, input bit stray_div);
    idle_inputs();
    flush            = fl;
    req_valid        = rv & fl;
    req_op           = op;
    div_result_valid = stray_div;
    @(negedge clk);
    check_cycle(1, 0, 0, 0, pend_done, m_hi, m_lo);
    end_cycle();
    pend_done = 1'b0;
  endtask

  task automatic do_mt_ill(input bit [2:0] op, input logic [31:0] a);
    logic [31:0] ehi, elo;
    idle_inputs();
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = a;
    ehi = (BYP && op == 3'd4) ? a : m_hi;
    elo = (BYP && op == 3'd5) ? a : m_lo;
    @(negedge clk);
    check_cycle(1, 0, 0, 0, pend_done, ehi, elo);
    m_in1 = a;
    m_in2 = req_src2;
    m_sgn = 1'b0;
    end_cycle();
    if (op == 3'd4) m_hi = a;
    if (op == 3'd5) m_lo = a;
    pend_done = (op == 3'd4) || (op == 3'd5);
  endtask

  task automatic do_mul(input bit sgn, input logic [31:0] a, input logic [31:0] b, input int fl_cyc);
    logic [63:0] prod;
    bit commit;
    if (sgn) prod = 64'(longint'($signed(a)) * longint'($signed(b)));
    else     prod = {32'd0, a} * {32'd0, b};
    idle_inputs();
    req_valid = 1'b1;
    req_op    = sgn ? 3'd0 : 3'd1;
    req_src1  = a;
    req_src2  = b;
    @(negedge clk);
    check_cycle(1, 0, 0, 0, pend_done, m_hi, m_lo);
    end_cycle();
    m_in1 = a; m_in2 = b; m_sgn = sgn; pend_done = 1'b0;
    for (int c = 1; c <= 1 + L; c++) begin
      idle_inputs();
      req_valid = 1'($urandom_range(0, 1));
      flush     = (c == fl_cyc);
      if (c == 1 + L) mul_result = prod;
      commit = (c == 1 + L) && !flush;
      @(negedge clk);
      check_cycle(0, 1, c == 1, 0, 0, (BYP && commit) ? prod[63:32] : m_hi,
                  (BYP && commit) ? prod[31:0] : m_lo);
      end_cycle();
      if (c == fl_cyc) break;
      if (commit) begin
        m_hi = prod[63:32]; m_lo = prod[31:0]; pend_done = 1'b1;
      end
    end
  endtask

  task automatic do_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        input int n, input int fl_cyc);
    logic [31:0] q, r;
    longint sa, sb, q64, r64;
    bit commit;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (sgn) begin
      sa = longint'($signed(a)); sb = longint'($signed(b));
      q64 = sa / sb; r64 = sa % sb;
      q = q64[31:0]; r = r64[31:0];
    end else begin
      q = a / b; r = a % b;
    end
    idle_inputs();
    req_valid = 1'b1;
    req_op    = sgn ? 3'd2 : 3'd3;
    req_src1  = a;
    req_src2  = b;
    @(negedge clk);
    check_cycle(1, 0, 0, 0, pend_done, m_hi, m_lo);
    end_cycle();
    m_in1 = a; m_in2 = b; m_sgn = sgn; pend_done = 1'b0;
    for (int c = 1; c <= n; c++) begin
      idle_inputs();
      req_valid = 1'($urandom_range(0, 1));
      flush     = (c == fl_cyc);
      if (c == n) begin
        div_result_valid = 1'b1; div_quotient = q; div_remainder = r;
      end
      commit = (c == n) && !flush;
      @(negedge clk);
      check_cycle(0, 1, 0, 1, 0, (BYP && commit) ? r : m_hi, (BYP && commit) ? q : m_lo);
      end_cycle();
      if (c == fl_cyc) break;
      if (commit) begin
        m_hi = r; m_lo = q; pend_done = 1'b1;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, n, f;
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    #12;
    check_cycle(1, 0, 0, 0, 0, 32'd0, 32'd0);
    rst_n = 1'b1;
    end_cycle();

    do_mul(1'b1, 32'hFFFF_FFFE, 32'd3, 0);
    do_div(1'b0, 32'd100, 32'd7, 33, 0);
    do_mt_ill(3'd4, 32'h1234_5678);
    do_mt_ill(3'd5, 32'h9ABC_DEF0);
    do_idle(0, 0, 3'd0, 0);
    do_div(1'b1, 32'hFFFF_FF00, 32'd5, 40, 10);
    do_idle(0, 0, 3'd0, 1);
    do_idle(0, 0, 3'd0, 1);
    do_mul(1'b0, $urandom, $urandom, 1 + L);
    do_idle(1, 1, 3'd5, 0);
    do_mul(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_mt_ill(3'd6, $urandom);
    do_mt_ill(3'd7, $urandom);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5, 5);
    do_div(1'b0, 32'd42, 32'd0, 3, 0);

    // reset asserted in the middle of DIV_WAIT
    do_div(1'b0, 32'd1000, 32'd3, 30, 6);
    idle_inputs();
    req_valid = 1'b1; req_op = 3'd3;
    @(negedge clk);
    check_cycle(1, 0, 0, 0, pend_done, m_hi, m_lo);
    end_cycle();
    m_in1 = req_src1; m_in2 = req_src2; m_sgn = 1'b0;
    for (int c = 0; c < 4; c++) begin
      idle_inputs();
      @(negedge clk);
      check_cycle(0, 1, 0, 1, 0, m_hi, m_lo);
      end_cycle();
    end
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_cycle(1, 0, 0, 0, 0, 32'd0, 32'd0);
    #1 rst_n = 1'b1;
    end_cycle();

    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1: begin
          f = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 1 + L) : 0;
          do_mul(1'($urandom_range(0, 1)), $urandom, $urandom, f);
        end
        2, 3: begin
          n = $urandom_range(1, 40);
          f = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n) : 0;
          do_div(1'($urandom_range(0, 1)), $urandom,
                 ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom, n, f);
        end
        4, 5: do_mt_ill(3'($urandom_range(4, 5)), $urandom);
        6: do_mt_ill(3'($urandom_range(6, 7)), $urandom);
        default: do_idle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      endcase
    end
    do_idle(0, 0, 3'd0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
